// File: rtl/ddr2_input_packer_if.sv
// Sample-side and FIFO-side signal bundle for ddr2_input_packer.
// The packer uses the slave view; the acquisition/FIFO side uses the master view.
interface ddr2_input_packer_if;
  logic        enable;
  logic [15:0] word_in;
  logic        word_we;
  logic        flush;
  logic [31:0] fifo_din;
  logic        fifo_we;
  logic        fifo_full;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] total_words;

  modport master (
    output enable, word_in, word_we, flush, fifo_full,
    input  fifo_din, fifo_we, busy, overflow, drop_count, total_words
  );

  modport slave (
    input  enable, word_in, word_we, flush, fifo_full,
    output fifo_din, fifo_we, busy, overflow, drop_count, total_words
  );
endinterface

// File: rtl/ddr2_input_packer.sv
// Packs 16-bit samples into 32-bit FIFO words, pads to burst-group boundaries on flush.
// Define DDR2_INPUT_PACKER_STATS_EN to enable the total_words write counter.
module ddr2_input_packer #(
  parameter int          GROUP_WORDS = 4,
  parameter logic [15:0] PAD_WORD    = 16'h0000
) (
  input logic            clk,
  input logic            reset,
  ddr2_input_packer_if.slave bus
);

  localparam int PW = $clog2(GROUP_WORDS);

  typedef enum logic {S_RUN, S_PAD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q;
  logic [15:0]   half_q;
  logic [31:0]   din_q;
  logic          we_q;
  logic          overflow_q;
  logic [15:0]   drop_q;

  logic          word_valid;
  logic [15:0]   word_val;
  logic [PW-1:0] phase_next;
  logic          pair_done;
  logic          pad_drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    word_valid = 1'b0;
    word_val   = bus.word_in;
    pad_drop   = 1'b0;
    state_d    = state_q;

    if (state_q == S_PAD) begin
      // Padding runs regardless of enable; enable only gates the inputs.
      word_valid = 1'b1;
      word_val   = PAD_WORD;
      pad_drop   = bus.enable & bus.word_we;
    end else begin
      word_valid = bus.enable & bus.word_we;
    end

    phase_next = word_valid ? phase_q + PW'(1) : phase_q;
    pair_done  = word_valid & phase_q[0];

    case (state_q)
      S_RUN: if (bus.enable && bus.flush && phase_next != '0) state_d = S_PAD;
      S_PAD: if (phase_next == '0) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    state_q <= reset ? S_RUN : state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      half_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      phase_q <= phase_next;
      we_q    <= pair_done & ~bus.fifo_full;

      if (word_valid && !phase_q[0]) half_q <= word_val;

      if (pair_done && !bus.fifo_full) din_q <= {word_val, half_q};

      // A full FIFO drops the pair but the phase still advances to keep group alignment.
      if (pair_done && bus.fifo_full) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end

      if (pad_drop) overflow_q <= 1'b1;
    end
  end

  assign bus.fifo_din   = din_q;
  assign bus.fifo_we    = we_q;
  assign bus.busy       = (state_q == S_PAD);
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;

`ifdef DDR2_INPUT_PACKER_STATS_EN
  logic [31:0] total_q;

  always_ff @(posedge clk) begin
    if (reset)      total_q <= '0;
    else if (we_q)  total_q <= total_q + 32'd1;
  end

  assign bus.total_words = total_q;
`else
  assign bus.total_words = '0;
`endif

endmodule

// File: tb/tb_ddr2_input_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_ddr2_input_packer;

  localparam int          G   = 4;
  localparam logic [15:0] PAD = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  ddr2_input_packer_if bus ();

  ddr2_input_packer #(.GROUP_WORDS(G), .PAD_WORD(PAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending 16-bit words wait in a queue until a pair is complete.
  logic [15:0]  pend_q[$];
  int           pos;        // words accepted modulo G
  int           pad_left;   // pad words still to insert
  bit           exp_we;
  logic [31:0]  exp_din;
  bit           exp_ovf;
  int           exp_drop;
  int unsigned  exp_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    pos = 0; pad_left = 0;
    exp_we = 0; exp_din = '0; exp_ovf = 0; exp_drop = 0; exp_total = 0;
  endtask

  task automatic model_push(input logic [15:0] w, input bit full);
    pend_q.push_back(w);
    pos = (pos + 1) % G;
    if (pend_q.size() == 2) begin
      if (full) begin
        exp_ovf = 1;
        if (exp_drop < 16'hFFFF) exp_drop++;
      end else begin
        exp_we    = 1;
        exp_din   = {pend_q[1], pend_q[0]};
        exp_total = exp_total + 1;
      end
      pend_q.delete();
    end
  endtask

  task automatic model_step(input bit en, input bit we, input logic [15:0] w,
                            input bit fl, input bit full);
    exp_we = 0;
    if (pad_left > 0) begin
      model_push(PAD, full);
      pad_left--;
      if (en && we) exp_ovf = 1;
    end else if (en) begin
      if (we) model_push(w, full);
      if (fl && pos != 0) pad_left = G - pos;
    end
  endtask

  task automatic compare_all();
    check("fifo_we",  {31'd0, bus.fifo_we},  {31'd0, exp_we});
    check("fifo_din", bus.fifo_din,          exp_din);
    check("busy",     {31'd0, bus.busy},     {31'd0, pad_left > 0});
    check("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
    check("drop",     {16'd0, bus.drop_count}, exp_drop);
`ifdef DDR2_INPUT_PACKER_STATS_EN
    check("total",    bus.total_words,       exp_total);
`else
    check("total",    bus.total_words,       32'd0);
`endif
  endtask

  // One clock: drive inputs away from the edge, advance the model, sample #1 after the edge.
  task automatic step(input bit en, input bit we, input logic [15:0] w,
                      input bit fl, input bit full);
    bus.enable = en; bus.word_we = we; bus.word_in = w;
    bus.flush = fl; bus.fifo_full = full;
    @(posedge clk);
    #1;
    model_step(en, we, w, fl, full);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.word_we = 1'b0; bus.word_in = '0;
    bus.flush = 1'b0; bus.fifo_full = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] seq1 [4];
    seq1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    do_reset();
    check("rst_din", bus.fifo_din, 32'h0);

    // Four consecutive words pack into two FIFO writes.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, seq1[i], 1'b0, 1'b0);
      if (i == 1) check("s1_din0", bus.fifo_din, 32'h2222_1111);
      if (i == 3) check("s1_din1", bus.fifo_din, 32'h4444_3333);
      check("s1_busy", {31'd0, bus.busy}, 32'd0);
    end

    // Three words then flush: one pad cycle.
    step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0);
    check("s2_din0", bus.fifo_din, 32'hBBBB_AAAA);
    step(1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0,    1'b1, 1'b0);
    check("s2_busy1", {31'd0, bus.busy}, 32'd1);
    idle();
    check("s2_din1", bus.fifo_din, {PAD, 16'hCCCC});
    check("s2_busy0", {31'd0, bus.busy}, 32'd0);

    // Single word with same-cycle flush: three pad cycles.
    step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0);
    check("s3_busy_a", {31'd0, bus.busy}, 32'd1);
    idle();
    check("s3_din0", bus.fifo_din, 32'h0000_ABCD);
    idle();
    check("s3_busy_b", {31'd0, bus.busy}, 32'd1);
    idle();
    check("s3_din1", bus.fifo_din, 32'h0000_0000);
    check("s3_busy_c", {31'd0, bus.busy}, 32'd0);

    // FIFO full across eight words, then four words with room.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(i + 1), 1'b0, 1'b1);
    check("s4_drop", {16'd0, bus.drop_count}, 32'd4);
    check("s4_ovf",  {31'd0, bus.overflow},   32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
    check("s4_din", bus.fifo_din, 32'h5003_5002);

    // Word strobed while padding is dropped.
    do_reset();
    step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0,    1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("s5_ovf",  {31'd0, bus.overflow},   32'd1);
    check("s5_din",  bus.fifo_din, {PAD, 16'h1234});
    idle(); idle();
    check("s5_drop", {16'd0, bus.drop_count}, 32'd0);

    // Reset mid-padding, then a flush with nothing buffered.
    step(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check("s6_busy", {31'd0, bus.busy},    32'd0);
    check("s6_we",   {31'd0, bus.fifo_we}, 32'd0);
    check("s6_din",  bus.fifo_din,         32'd0);

    // Randomized traffic, including enable gating and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      else step($urandom_range(9) != 0, $urandom_range(9) < 6, 16'($urandom),
                $urandom_range(19) == 0, $urandom_range(6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
